// File: rtl/sd_spi_master.sv
// ============================================================================
//  Module   : sd_spi_master
//  Brief    : SPI mode-0 byte engine driving the SD card interface, with
//             selectable slow (initialisation) and fast (data) clock rates.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_spi_master #(
    parameter int SLOW_DIV = 63,
    parameter int FAST_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       fast,
    input  logic       cs_assert,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sdSCLK,
    output logic       sdMOSI,
    input  logic       sdMISO,
    output logic       sdCS
);

    localparam int c_MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int c_CW      = (c_MAX_DIV < 1) ? 1 : $clog2(c_MAX_DIV + 1);

    localparam logic [c_CW-1:0] c_SLOW = c_CW'(SLOW_DIV);
    localparam logic [c_CW-1:0] c_FAST = c_CW'(FAST_DIV);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOW  = 2'd1;
    localparam logic [1:0] c_S_HIGH = 2'd2;

    logic [1:0]      r_state,  w_state_nxt;
    logic [c_CW-1:0] r_cnt,    w_cnt_nxt;
    logic [c_CW-1:0] r_div,    w_div_nxt;
    logic [2:0]      r_bit,    w_bit_nxt;
    logic [7:0]      r_tx_sh,  w_tx_sh_nxt;
    logic [7:0]      r_rx_sh,  w_rx_sh_nxt;
    logic [7:0]      r_rx,     w_rx_nxt;
    logic            r_sclk,   w_sclk_nxt;
    logic            r_mosi,   w_mosi_nxt;
    logic            r_cs,     w_cs_nxt;
    logic            r_busy,   w_busy_nxt;
    logic            r_done,   w_done_nxt;
    logic            w_tick;

    // r_div holds H-1, so a half-period ends when the counter matches it
    assign w_tick = (r_cnt == r_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_bit   <= 3'd0;
            r_tx_sh <= 8'h00;
            r_rx_sh <= 8'h00;
            r_rx    <= 8'h00;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b1;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_tx_sh <= w_tx_sh_nxt;
            r_rx_sh <= w_rx_sh_nxt;
            r_rx    <= w_rx_nxt;
            r_sclk  <= w_sclk_nxt;
            r_mosi  <= w_mosi_nxt;
            r_cs    <= w_cs_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (start)  w_state_nxt = c_S_LOW;
            c_S_LOW:  if (w_tick) w_state_nxt = c_S_HIGH;
            c_S_HIGH: if (w_tick) w_state_nxt = (r_bit == 3'd7) ? c_S_IDLE : c_S_LOW;
            default:              w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt   = r_cnt + 1'b1;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_tx_sh_nxt = r_tx_sh;
        w_rx_sh_nxt = r_rx_sh;
        w_rx_nxt    = r_rx;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_cs_nxt    = r_cs;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_cs_nxt  = ~cs_assert;
                w_cnt_nxt = '0;
                if (start) begin
                    w_tx_sh_nxt = tx_data;
                    w_div_nxt   = fast ? c_FAST : c_SLOW;
                    w_mosi_nxt  = tx_data[7];
                    w_busy_nxt  = 1'b1;
                    w_bit_nxt   = 3'd0;
                end
            end
            c_S_LOW: begin
                if (w_tick) begin
                    w_sclk_nxt  = 1'b1;
                    w_rx_sh_nxt = {r_rx_sh[6:0], sdMISO};
                    w_cnt_nxt   = '0;
                end
            end
            c_S_HIGH: begin
                if (w_tick) begin
                    w_sclk_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                    if (r_bit == 3'd7) begin
                        w_rx_nxt   = r_rx_sh;
                        w_busy_nxt = 1'b0;
                        w_done_nxt = 1'b1;
                        w_mosi_nxt = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_sh_nxt = {r_tx_sh[6:0], 1'b0};
                        w_mosi_nxt  = r_tx_sh[6];
                    end
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    assign rx_data = r_rx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sdSCLK  = r_sclk;
    assign sdMOSI  = r_mosi;
    assign sdCS    = r_cs;

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_master.sv
// ============================================================================
//  Module   : tb_sd_spi_master
//  Brief    : Self-checking bench for sd_spi_master with a card responder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sd_spi_master;

    localparam int SLOW_DIV = 63;
    localparam int FAST_DIV = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       fast = 1'b0;
    logic       cs_assert = 1'b0;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       sdSCLK;
    logic       sdMOSI;
    logic       sdMISO = 1'b1;
    logic       sdCS;

    sd_spi_master #(.SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .fast(fast), .cs_assert(cs_assert), .rx_data(rx_data), .busy(busy),
        .done(done), .sdSCLK(sdSCLK), .sdMOSI(sdMOSI), .sdMISO(sdMISO),
        .sdCS(sdCS)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] resp;
        logic       fast;
        logic       cs_a;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
        int         exp_lat;
    } vec_t;

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         q_rise[$];
    logic       q_mosi[$];
    int         q_done[$];
    logic [7:0] q_resp[$];
    logic [7:0] resp_sh = 8'hFF;
    logic       m_prev_sclk = 1'b0;
    int         cs_bad = 0;
    logic       cs_exp = 1'b1;
    vec_t       vecs[16];

    // Card responder and bus monitor: MISO moves on falling SCLK
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (sdSCLK === 1'b1 && m_prev_sclk === 1'b0) begin
            q_rise.push_back(cyc);
            q_mosi.push_back(sdMOSI);
        end
        if (sdSCLK === 1'b0 && m_prev_sclk === 1'b1) begin
            resp_sh = {resp_sh[6:0], 1'b0};
            sdMISO  = resp_sh[7];
        end
        if (done === 1'b1) begin
            q_done.push_back(cyc);
            if (q_resp.size() > 0) begin
                resp_sh = q_resp.pop_front();
                sdMISO  = resp_sh[7];
            end
        end
        if (busy === 1'b1 && sdCS !== cs_exp) cs_bad++;
        m_prev_sclk = sdSCLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int model_h(input logic f);
        return f ? FAST_DIV + 1 : SLOW_DIV + 1;
    endfunction

    function automatic vec_t mk_vec(input logic [7:0] tx, input logic [7:0] resp,
                                    input logic f, input logic cs_a);
        vec_t v;
        v.tx       = tx;
        v.resp     = resp;
        v.fast     = f;
        v.cs_a     = cs_a;
        v.exp_rx   = resp;
        v.exp_mosi = tx;
        v.exp_lat  = 16 * model_h(f);
        return v;
    endfunction

    task automatic clear_mon();
        q_rise.delete();
        q_mosi.delete();
        q_done.delete();
        q_resp.delete();
        cs_bad = 0;
    endtask

    function automatic logic [31:0] pack_mosi(input int first, input int n);
        logic [31:0] m = 32'd0;
        for (int i = 0; i < n; i++) m = {m[30:0], q_mosi[first+i]};
        return m;
    endfunction

    task automatic chk_reset_vals(input string nm);
        chk({nm, " sclk"}, 32'(sdSCLK), 32'd0);
        chk({nm, " mosi"}, 32'(sdMOSI), 32'd1);
        chk({nm, " cs"},   32'(sdCS),   32'd1);
        chk({nm, " busy"}, 32'(busy),   32'd0);
        chk({nm, " done"}, 32'(done),   32'd0);
        chk({nm, " rx"},   32'(rx_data), 32'h00);
    endtask

    task automatic run_xfer(input vec_t v, input string nm);
        int k;
        int h;
        int to;
        h = model_h(v.fast);
        @(negedge clk);
        clear_mon();
        cs_exp    = ~v.cs_a;
        tx_data   = v.tx;
        fast      = v.fast;
        cs_assert = v.cs_a;
        start     = 1'b1;
        resp_sh   = v.resp;
        sdMISO    = v.resp[7];
        k         = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy_set"}, 32'(busy), 32'd1);
        to = 0;
        while (q_done.size() == 0 && to < 3000) begin
            @(negedge clk);
            to++;
        end
        if (q_done.size() == 0) begin
            chk({nm, " done_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({nm, " rx"},        32'(rx_data), 32'(v.exp_rx));
        chk({nm, " latency"},   32'(q_done[0] - k), 32'(v.exp_lat));
        chk({nm, " busy_clr"},  32'(busy), 32'd0);
        chk({nm, " rises"},     32'(q_rise.size()), 32'd8);
        if (q_rise.size() >= 8) begin
            chk({nm, " mosi"},       pack_mosi(0, 8), 32'(v.exp_mosi));
            chk({nm, " first_rise"}, 32'(q_rise[0] - k), 32'(h));
            chk({nm, " period"},     32'(q_rise[1] - q_rise[0]), 32'(2 * h));
        end
        chk({nm, " cs"}, 32'(cs_bad), 32'd0);
        repeat (3) @(negedge clk);
        chk({nm, " one_done"}, 32'(q_done.size()), 32'd1);
    endtask

    initial begin
        int to;
        int nacc;
        int nd;
        logic pb;
        logic [7:0] b2b_rx[3];

        vecs[0] = mk_vec(8'hA5, 8'h3C, 1'b1, 1'b1);
        vecs[1] = mk_vec(8'hFF, 8'h00, 1'b0, 1'b1);
        vecs[2] = mk_vec(8'hC3, 8'h5A, 1'b1, 1'b0);
        vecs[3] = mk_vec(8'h00, 8'hFF, 1'b1, 1'b1);
        for (int i = 4; i < 16; i++)
            vecs[i] = mk_vec(8'($urandom), 8'($urandom),
                             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

        // Asynchronous reset, observed before any clk edge
        #3 reset = 1'b1;
        #1 chk_reset_vals("reset_async");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        clear_mon();
        repeat (100) @(negedge clk);
        chk("idle_no_sclk", 32'(q_rise.size()), 32'd0);
        chk("idle_sclk_low", 32'(sdSCLK), 32'd0);

        for (int i = 0; i < 16; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Start and cs_assert changes while busy must not disturb the byte
        @(negedge clk);
        clear_mon();
        cs_exp = 1'b0; cs_assert = 1'b1; fast = 1'b1; tx_data = 8'h5A;
        resp_sh = 8'h00; sdMISO = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while (q_rise.size() < 4 && to < 100) begin @(negedge clk); to++; end
        start = 1'b1; tx_data = 8'h11; cs_assert = 1'b0;
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while (done !== 1'b1 && to < 100) begin @(negedge clk); to++; end
        chk("ign done_seen", 32'(done), 32'd1);
        chk("ign cs_in_done", 32'(sdCS), 32'd0);
        @(negedge clk);
        chk("ign cs_rise", 32'(sdCS), 32'd1);
        repeat (40) @(negedge clk);
        chk("ign one_done", 32'(q_done.size()), 32'd1);
        chk("ign rises", 32'(q_rise.size()), 32'd8);
        if (q_rise.size() >= 8) chk("ign mosi", pack_mosi(0, 8), 32'h5A);
        chk("ign busy", 32'(busy), 32'd0);
        chk("ign cs_frozen", 32'(cs_bad), 32'd0);

        // Back-to-back with start held high
        @(negedge clk);
        clear_mon();
        b2b_rx[0] = 8'h81; b2b_rx[1] = 8'h42; b2b_rx[2] = 8'h24;
        q_resp.push_back(b2b_rx[1]);
        q_resp.push_back(b2b_rx[2]);
        resp_sh = b2b_rx[0]; sdMISO = b2b_rx[0][7];
        cs_exp = 1'b0; cs_assert = 1'b1; fast = 1'b1; tx_data = 8'h01; start = 1'b1;
        nacc = 0; nd = 0; pb = 1'b0; to = 0;
        while (nd < 3 && to < 300) begin
            @(negedge clk);
            to++;
            if (busy === 1'b1 && pb === 1'b0) begin
                nacc++;
                if (nacc == 1) tx_data = 8'h02;
                else if (nacc == 2) tx_data = 8'h03;
                else start = 1'b0;
            end
            if (done === 1'b1) begin
                chk($sformatf("b2b gap_mosi%0d", nd), 32'(sdMOSI), 32'd1);
                chk($sformatf("b2b gap_sclk%0d", nd), 32'(sdSCLK), 32'd0);
                chk($sformatf("b2b rx%0d", nd), 32'(rx_data), 32'(b2b_rx[nd]));
                nd++;
            end
            pb = busy;
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b dones", 32'(q_done.size()), 32'd3);
        if (q_done.size() >= 3) begin
            chk("b2b space1", 32'(q_done[1] - q_done[0]), 32'd33);
            chk("b2b space2", 32'(q_done[2] - q_done[1]), 32'd33);
        end
        chk("b2b rises", 32'(q_mosi.size()), 32'd24);
        if (q_mosi.size() >= 24) chk("b2b mosi", pack_mosi(0, 24), 32'h010203);

        // Abort mid-byte with reset, then recover
        @(negedge clk);
        clear_mon();
        cs_exp = 1'b0; cs_assert = 1'b1; fast = 1'b1; tx_data = 8'h96;
        resp_sh = 8'hE7; sdMISO = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while (q_rise.size() < 5 && to < 100) begin @(negedge clk); to++; end
        chk("abort reached_rise5", 32'(q_rise.size()), 32'd5);
        #2 reset = 1'b1;
        #1 chk_reset_vals("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort no_done", 32'(q_done.size()), 32'd0);
        run_xfer(mk_vec(8'hC3, 8'h69, 1'b1, 1'b1), "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
